// File: rtl/rocket_group_object_if.sv
// Bus between the rocket group and its environment: launch handshake,
// VGA pixel scan, collision feedback and the per-pixel draw outputs.
interface rocket_group_object_if #(
   parameter int NUM_ROCKETS = 4
);
   logic                   startOfFrame;
   logic [10:0]            pixelX;
   logic [10:0]            pixelY;
   logic                   fireRequest;
   logic [10:0]            fireX;
   logic [10:0]            fireY;
   logic [1:0]             fireDir;
   logic                   hitPulse;
   logic                   fireAck;
   logic                   fullFlag;
   logic [NUM_ROCKETS-1:0] activeMask;
   logic [2:0]             hitIndex;
   logic [10:0]            offsetX;
   logic [10:0]            offsetY;
   logic                   drawingRequest;
   logic [7:0]             RGBout;

   modport master (
      output startOfFrame, pixelX, pixelY, fireRequest, fireX, fireY, fireDir, hitPulse,
      input  fireAck, fullFlag, activeMask, hitIndex, offsetX, offsetY, drawingRequest, RGBout
   );

   modport slave (
      input  startOfFrame, pixelX, pixelY, fireRequest, fireX, fireY, fireDir, hitPulse,
      output fireAck, fullFlag, activeMask, hitIndex, offsetX, offsetY, drawingRequest, RGBout
   );
endinterface

// File: rtl/rocket_group_object.sv
// Multi-slot rocket object: per-slot idle/fly/explode state machines, lowest-free-slot
// launch, once-per-frame motion, and a one-cycle registered pixel draw path.
module rocket_group_object #(
   parameter int         NUM_ROCKETS     = 4,
   parameter int         OBJECT_WIDTH_X  = 8,
   parameter int         OBJECT_HEIGHT_Y = 8,
   parameter int         SPEED           = 4,
   parameter int         SCREEN_W        = 640,
   parameter int         SCREEN_H        = 480,
   parameter int         EXPLODE_FRAMES  = 8,
   parameter logic [7:0] OBJECT_COLOR    = 8'h5b,
   parameter logic [7:0] EXPLODE_COLOR   = 8'hE0
) (
   input logic                   clk,
   input logic                   reset,
   rocket_group_object_if.slave  bus
);

   localparam int CNT_W = (EXPLODE_FRAMES > 1) ? $clog2(EXPLODE_FRAMES) : 1;
   localparam logic signed [11:0] STEP  = 12'(SPEED);
   localparam logic signed [11:0] MAX_X = 12'(SCREEN_W - OBJECT_WIDTH_X);
   localparam logic signed [11:0] MAX_Y = 12'(SCREEN_H - OBJECT_HEIGHT_Y);

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_FLY = 2'd1, S_EXPL = 2'd2} slot_state_t;

   slot_state_t             st_q  [NUM_ROCKETS];
   slot_state_t             st_d  [NUM_ROCKETS];
   logic signed [11:0]      x_q   [NUM_ROCKETS];
   logic signed [11:0]      x_d   [NUM_ROCKETS];
   logic signed [11:0]      y_q   [NUM_ROCKETS];
   logic signed [11:0]      y_d   [NUM_ROCKETS];
   logic [1:0]              dir_q [NUM_ROCKETS];
   logic [1:0]              dir_d [NUM_ROCKETS];
   logic [CNT_W-1:0]        cnt_q [NUM_ROCKETS];
   logic [CNT_W-1:0]        cnt_d [NUM_ROCKETS];

   logic                    fire_go;
   logic [2:0]              fire_idx;
   logic                    hit_go;
   logic [NUM_ROCKETS-1:0]  mask_d;
   logic                    win;
   logic                    win_expl;
   logic [2:0]              win_idx;
   logic [10:0]             offx;
   logic [10:0]             offy;
   logic [11:0]             px;
   logic [11:0]             py;

   logic                    fire_ack_p1;
   logic                    full_p1;
   logic [NUM_ROCKETS-1:0]  mask_p1;
   logic [2:0]              hit_index_p1;
   logic [10:0]             offx_p1;
   logic [10:0]             offy_p1;
   logic                    draw_p1;
   logic [7:0]              rgb_p1;

   // Launch target is chosen from the current state, so a slot retiring this cycle is not reused
   always_comb begin
      fire_go  = 1'b0;
      fire_idx = 3'd0;
      for (int i = NUM_ROCKETS - 1; i >= 0; i--) begin
         if (st_q[i] == S_IDLE) begin
            fire_go  = bus.fireRequest;
            fire_idx = 3'(i);
         end
      end
   end

   assign hit_go = bus.hitPulse & draw_p1;

   always_comb begin
      logic signed [11:0] nx;
      logic signed [11:0] ny;
      nx = 12'sd0;
      ny = 12'sd0;
      for (int i = 0; i < NUM_ROCKETS; i++) begin
         st_d[i]  = st_q[i];
         x_d[i]   = x_q[i];
         y_d[i]   = y_q[i];
         dir_d[i] = dir_q[i];
         cnt_d[i] = cnt_q[i];
         nx = x_q[i];
         ny = y_q[i];
         case (dir_q[i])
            2'd0:    ny = y_q[i] - STEP;
            2'd1:    nx = x_q[i] + STEP;
            2'd2:    ny = y_q[i] + STEP;
            default: nx = x_q[i] - STEP;
         endcase
         case (st_q[i])
            S_IDLE: begin
               if (fire_go && fire_idx == 3'(i)) begin
                  st_d[i]  = S_FLY;
                  x_d[i]   = {1'b0, bus.fireX};
                  y_d[i]   = {1'b0, bus.fireY};
                  dir_d[i] = bus.fireDir;
               end
            end
            S_FLY: begin
               // A hit takes priority over the frame move and freezes the position
               if (hit_go && hit_index_p1 == 3'(i)) begin
                  st_d[i]  = S_EXPL;
                  cnt_d[i] = CNT_W'(EXPLODE_FRAMES - 1);
               end else if (bus.startOfFrame) begin
                  if (nx < 12'sd0 || nx > MAX_X || ny < 12'sd0 || ny > MAX_Y) begin
                     st_d[i] = S_IDLE;
                  end else begin
                     x_d[i] = nx;
                     y_d[i] = ny;
                  end
               end
            end
            S_EXPL: begin
               if (bus.startOfFrame) begin
                  if (cnt_q[i] == '0) st_d[i] = S_IDLE;
                  else                cnt_d[i] = cnt_q[i] - 1'b1;
               end
            end
            default: st_d[i] = S_IDLE;
         endcase
      end
   end

   always_comb begin
      mask_d = '0;
      for (int i = 0; i < NUM_ROCKETS; i++) mask_d[i] = (st_d[i] != S_IDLE);
   end

   // Positions never go negative, so an unsigned compare against the pixel is exact
   assign px = {1'b0, bus.pixelX};
   assign py = {1'b0, bus.pixelY};

   always_comb begin
      win      = 1'b0;
      win_expl = 1'b0;
      win_idx  = 3'd0;
      offx     = 11'd0;
      offy     = 11'd0;
      for (int i = NUM_ROCKETS - 1; i >= 0; i--) begin
         if (st_q[i] != S_IDLE &&
             px >= $unsigned(x_q[i]) && px < $unsigned(x_q[i]) + 12'(OBJECT_WIDTH_X) &&
             py >= $unsigned(y_q[i]) && py < $unsigned(y_q[i]) + 12'(OBJECT_HEIGHT_Y)) begin
            win      = 1'b1;
            win_expl = (st_q[i] == S_EXPL);
            win_idx  = 3'(i);
            offx     = 11'(px - $unsigned(x_q[i]));
            offy     = 11'(py - $unsigned(y_q[i]));
         end
      end
   end

   // Stage boundary: slot state and all outputs registered on the same edge
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NUM_ROCKETS; i++) begin
            st_q[i]  <= S_IDLE;
            x_q[i]   <= 12'sd0;
            y_q[i]   <= 12'sd0;
            dir_q[i] <= 2'd0;
            cnt_q[i] <= '0;
         end
         fire_ack_p1  <= 1'b0;
         full_p1      <= 1'b0;
         mask_p1      <= '0;
         hit_index_p1 <= 3'd0;
         offx_p1      <= 11'd0;
         offy_p1      <= 11'd0;
         draw_p1      <= 1'b0;
         rgb_p1       <= 8'hFF;
      end else begin
         for (int i = 0; i < NUM_ROCKETS; i++) begin
            st_q[i]  <= st_d[i];
            x_q[i]   <= x_d[i];
            y_q[i]   <= y_d[i];
            dir_q[i] <= dir_d[i];
            cnt_q[i] <= cnt_d[i];
         end
         fire_ack_p1 <= fire_go;
         full_p1     <= &mask_d;
         mask_p1     <= mask_d;
         offx_p1     <= offx;
         offy_p1     <= offy;
         draw_p1     <= win;
         rgb_p1      <= win ? (win_expl ? EXPLODE_COLOR : OBJECT_COLOR) : 8'hFF;
         if (win) hit_index_p1 <= win_idx;
      end
   end

   assign bus.fireAck        = fire_ack_p1;
   assign bus.fullFlag       = full_p1;
   assign bus.activeMask     = mask_p1;
   assign bus.hitIndex       = hit_index_p1;
   assign bus.offsetX        = offx_p1;
   assign bus.offsetY        = offy_p1;
   assign bus.drawingRequest = draw_p1;
   assign bus.RGBout         = rgb_p1;

endmodule

// File: tb/tb_rocket_group_object.sv
// Directed bench for rocket_group_object: launch, motion, edge exit, hit/explode,
// overlap priority, fire/frame coincidence and mid-flight reset.
module tb_rocket_group_object;
   logic clk = 1'b0;
   logic reset = 1'b0;
   int   checks = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   rocket_group_object_if #(.NUM_ROCKETS(4)) bus ();

   rocket_group_object #(.NUM_ROCKETS(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      bus.startOfFrame = 1'b0;
      bus.pixelX       = 11'd0;
      bus.pixelY       = 11'd0;
      bus.fireRequest  = 1'b0;
      bus.fireX        = 11'd0;
      bus.fireY        = 11'd0;
      bus.fireDir      = 2'd0;
      bus.hitPulse     = 1'b0;
   endtask

   task automatic hard_reset();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      tick();
   endtask

   task automatic fire(input int x, input int y, input int d);
      bus.fireRequest = 1'b1;
      bus.fireX = 11'(x);
      bus.fireY = 11'(y);
      bus.fireDir = 2'(d);
      tick();
      bus.fireRequest = 1'b0;
   endtask

   task automatic frame();
      bus.startOfFrame = 1'b1;
      tick();
      bus.startOfFrame = 1'b0;
   endtask

   task automatic look(input int x, input int y);
      bus.pixelX = 11'(x);
      bus.pixelY = 11'(y);
      tick();
   endtask

   task automatic test_reset();
      #2 reset = 1'b1;
      #1;
      checks++; if (bus.fireAck !== 1'b0) begin failures++; $display("FAIL rst_ack got=%b exp=0", bus.fireAck); end
      checks++; if (bus.fullFlag !== 1'b0) begin failures++; $display("FAIL rst_full got=%b exp=0", bus.fullFlag); end
      checks++; if (bus.activeMask !== 4'h0) begin failures++; $display("FAIL rst_mask got=%h exp=0", bus.activeMask); end
      checks++; if (bus.hitIndex !== 3'd0) begin failures++; $display("FAIL rst_hidx got=%0d exp=0", bus.hitIndex); end
      checks++; if (bus.offsetX !== 11'd0 || bus.offsetY !== 11'd0) begin failures++; $display("FAIL rst_off got=%0d,%0d exp=0,0", bus.offsetX, bus.offsetY); end
      checks++; if (bus.drawingRequest !== 1'b0) begin failures++; $display("FAIL rst_dr got=%b exp=0", bus.drawingRequest); end
      checks++; if (bus.RGBout !== 8'hFF) begin failures++; $display("FAIL rst_rgb got=%h exp=ff", bus.RGBout); end
      tick();
      reset = 1'b0;
      tick();
   endtask

   task automatic test_fire_move();
      hard_reset();
      fire(100, 200, 1);
      checks++; if (bus.fireAck !== 1'b1) begin failures++; $display("FAIL fm_ack got=%b exp=1", bus.fireAck); end
      checks++; if (bus.activeMask !== 4'b0001) begin failures++; $display("FAIL fm_mask got=%b exp=0001", bus.activeMask); end
      tick();
      checks++; if (bus.fireAck !== 1'b0) begin failures++; $display("FAIL fm_ack_pulse got=%b exp=0", bus.fireAck); end
      frame(); frame(); frame();
      look(112, 200);
      checks++; if (bus.RGBout !== 8'h5b) begin failures++; $display("FAIL fm_rgb got=%h exp=5b", bus.RGBout); end
      checks++; if (bus.drawingRequest !== 1'b1) begin failures++; $display("FAIL fm_dr got=%b exp=1", bus.drawingRequest); end
      checks++; if (bus.offsetX !== 11'd0 || bus.offsetY !== 11'd0) begin failures++; $display("FAIL fm_off got=%0d,%0d exp=0,0", bus.offsetX, bus.offsetY); end
      look(119, 207);
      checks++; if (bus.offsetX !== 11'd7 || bus.offsetY !== 11'd7) begin failures++; $display("FAIL fm_off_far got=%0d,%0d exp=7,7", bus.offsetX, bus.offsetY); end
      look(120, 200);
      checks++; if (bus.drawingRequest !== 1'b0 || bus.RGBout !== 8'hFF) begin failures++; $display("FAIL fm_outside got=%b/%h exp=0/ff", bus.drawingRequest, bus.RGBout); end
      look(111, 200);
      checks++; if (bus.drawingRequest !== 1'b0 || bus.offsetX !== 11'd0) begin failures++; $display("FAIL fm_left got=%b/%0d exp=0/0", bus.drawingRequest, bus.offsetX); end
   endtask

   task automatic test_full();
      hard_reset();
      bus.fireRequest = 1'b1;
      for (int k = 0; k < 5; k++) begin
         bus.fireX = 11'(10 + 20 * k);
         bus.fireY = 11'd300;
         bus.fireDir = 2'd1;
         tick();
         checks++; if (bus.fireAck !== (k < 4)) begin failures++; $display("FAIL full_ack%0d got=%b exp=%b", k, bus.fireAck, (k < 4)); end
         checks++; if (bus.fullFlag !== (k >= 3)) begin failures++; $display("FAIL full_flag%0d got=%b exp=%b", k, bus.fullFlag, (k >= 3)); end
      end
      bus.fireRequest = 1'b0;
      checks++; if (bus.activeMask !== 4'hF) begin failures++; $display("FAIL full_mask got=%b exp=1111", bus.activeMask); end
      look(70, 300);
      checks++; if (bus.hitIndex !== 3'd3 || bus.drawingRequest !== 1'b1) begin failures++; $display("FAIL full_slot3 got=%0d/%b exp=3/1", bus.hitIndex, bus.drawingRequest); end
      look(90, 300);
      checks++; if (bus.drawingRequest !== 1'b0) begin failures++; $display("FAIL full_dropped got=%b exp=0", bus.drawingRequest); end
   endtask

   task automatic test_edge_exit();
      hard_reset();
      fire(628, 100, 1);
      frame();
      checks++; if (bus.activeMask !== 4'b0001) begin failures++; $display("FAIL edge_at_max got=%b exp=0001", bus.activeMask); end
      look(632, 100);
      checks++; if (bus.drawingRequest !== 1'b1 || bus.RGBout !== 8'h5b) begin failures++; $display("FAIL edge_draw got=%b/%h exp=1/5b", bus.drawingRequest, bus.RGBout); end
      frame();
      checks++; if (bus.activeMask !== 4'b0000 || bus.fullFlag !== 1'b0) begin failures++; $display("FAIL edge_exit got=%b/%b exp=0000/0", bus.activeMask, bus.fullFlag); end
      tick();
      checks++; if (bus.drawingRequest !== 1'b0 || bus.RGBout !== 8'hFF) begin failures++; $display("FAIL edge_no_expl got=%b/%h exp=0/ff", bus.drawingRequest, bus.RGBout); end
      fire(2, 50, 3);
      frame();
      checks++; if (bus.activeMask !== 4'b0000) begin failures++; $display("FAIL edge_left got=%b exp=0000", bus.activeMask); end
   endtask

   task automatic test_hit();
      hard_reset();
      fire(10, 10, 1);
      fire(30, 10, 1);
      fire(200, 150, 0);
      look(400, 400);
      bus.hitPulse = 1'b1;
      tick();
      bus.hitPulse = 1'b0;
      look(13, 12);
      checks++; if (bus.RGBout !== 8'h5b) begin failures++; $display("FAIL hit_ignored_nodraw got=%h exp=5b", bus.RGBout); end
      look(203, 152);
      checks++; if (bus.hitIndex !== 3'd2 || bus.RGBout !== 8'h5b) begin failures++; $display("FAIL hit_pre got=%0d/%h exp=2/5b", bus.hitIndex, bus.RGBout); end
      bus.hitPulse = 1'b1;
      bus.startOfFrame = 1'b1;
      tick();
      bus.hitPulse = 1'b0;
      bus.startOfFrame = 1'b0;
      checks++; if (bus.activeMask !== 4'b0111) begin failures++; $display("FAIL hit_mask got=%b exp=0111", bus.activeMask); end
      tick();
      checks++; if (bus.RGBout !== 8'hE0 || bus.offsetX !== 11'd3 || bus.offsetY !== 11'd2) begin failures++; $display("FAIL hit_expl got=%h/%0d,%0d exp=e0/3,2", bus.RGBout, bus.offsetX, bus.offsetY); end
      for (int f = 1; f <= 7; f++) begin
         frame();
         tick();
         checks++; if (bus.RGBout !== 8'hE0 || bus.offsetX !== 11'd3 || bus.offsetY !== 11'd2) begin failures++; $display("FAIL hit_frame%0d got=%h/%0d,%0d exp=e0/3,2", f, bus.RGBout, bus.offsetX, bus.offsetY); end
         if (f == 3) begin
            bus.hitPulse = 1'b1;
            tick();
            bus.hitPulse = 1'b0;
         end
      end
      frame();
      checks++; if (bus.activeMask !== 4'b0011) begin failures++; $display("FAIL hit_done_mask got=%b exp=0011", bus.activeMask); end
      tick();
      checks++; if (bus.drawingRequest !== 1'b0 || bus.RGBout !== 8'hFF || bus.offsetX !== 11'd0) begin failures++; $display("FAIL hit_done_draw got=%b/%h/%0d exp=0/ff/0", bus.drawingRequest, bus.RGBout, bus.offsetX); end
      checks++; if (bus.hitIndex !== 3'd2) begin failures++; $display("FAIL hit_idx_hold got=%0d exp=2", bus.hitIndex); end
   endtask

   task automatic test_overlap();
      hard_reset();
      fire(46, 46, 0);
      fire(48, 47, 1);
      look(50, 50);
      checks++; if (bus.hitIndex !== 3'd0 || bus.offsetX !== 11'd4 || bus.offsetY !== 11'd4) begin failures++; $display("FAIL ovl_slot0 got=%0d/%0d,%0d exp=0/4,4", bus.hitIndex, bus.offsetX, bus.offsetY); end
      checks++; if (bus.RGBout !== 8'h5b) begin failures++; $display("FAIL ovl_rgb got=%h exp=5b", bus.RGBout); end
      look(54, 50);
      checks++; if (bus.hitIndex !== 3'd1 || bus.offsetX !== 11'd6 || bus.offsetY !== 11'd3) begin failures++; $display("FAIL ovl_slot1 got=%0d/%0d,%0d exp=1/6,3", bus.hitIndex, bus.offsetX, bus.offsetY); end
   endtask

   task automatic test_fire_sof();
      hard_reset();
      fire(632, 10, 1);
      fire(100, 10, 1);
      bus.fireRequest = 1'b1;
      bus.fireX = 11'd300;
      bus.fireY = 11'd10;
      bus.fireDir = 2'd1;
      bus.startOfFrame = 1'b1;
      tick();
      bus.fireRequest = 1'b0;
      bus.startOfFrame = 1'b0;
      checks++; if (bus.fireAck !== 1'b1 || bus.activeMask !== 4'b0110) begin failures++; $display("FAIL fs_mask got=%b/%b exp=1/0110", bus.fireAck, bus.activeMask); end
      look(104, 10);
      checks++; if (bus.hitIndex !== 3'd1 || bus.offsetX !== 11'd0) begin failures++; $display("FAIL fs_moved got=%0d/%0d exp=1/0", bus.hitIndex, bus.offsetX); end
      look(300, 10);
      checks++; if (bus.hitIndex !== 3'd2 || bus.offsetX !== 11'd0 || bus.drawingRequest !== 1'b1) begin failures++; $display("FAIL fs_new got=%0d/%0d/%b exp=2/0/1", bus.hitIndex, bus.offsetX, bus.drawingRequest); end
   endtask

   task automatic test_reset_mid();
      hard_reset();
      fire(20, 400, 1);
      fire(40, 400, 1);
      fire(60, 400, 1);
      look(61, 401);
      checks++; if (bus.hitIndex !== 3'd2 || bus.drawingRequest !== 1'b1) begin failures++; $display("FAIL rm_pre got=%0d/%b exp=2/1", bus.hitIndex, bus.drawingRequest); end
      #2 reset = 1'b1;
      #1;
      checks++; if (bus.activeMask !== 4'h0 || bus.fullFlag !== 1'b0 || bus.fireAck !== 1'b0) begin failures++; $display("FAIL rm_ctrl got=%b/%b/%b exp=0000/0/0", bus.activeMask, bus.fullFlag, bus.fireAck); end
      checks++; if (bus.hitIndex !== 3'd0 || bus.offsetX !== 11'd0 || bus.offsetY !== 11'd0) begin failures++; $display("FAIL rm_idx got=%0d/%0d,%0d exp=0/0,0", bus.hitIndex, bus.offsetX, bus.offsetY); end
      checks++; if (bus.drawingRequest !== 1'b0 || bus.RGBout !== 8'hFF) begin failures++; $display("FAIL rm_draw got=%b/%h exp=0/ff", bus.drawingRequest, bus.RGBout); end
      #1 reset = 1'b0;
      look(61, 401);
      checks++; if (bus.drawingRequest !== 1'b0) begin failures++; $display("FAIL rm_gone got=%b exp=0", bus.drawingRequest); end
      fire(500, 400, 2);
      checks++; if (bus.fireAck !== 1'b1 || bus.activeMask !== 4'b0001) begin failures++; $display("FAIL rm_refire got=%b/%b exp=1/0001", bus.fireAck, bus.activeMask); end
      look(500, 400);
      checks++; if (bus.hitIndex !== 3'd0 || bus.drawingRequest !== 1'b1) begin failures++; $display("FAIL rm_slot0 got=%0d/%b exp=0/1", bus.hitIndex, bus.drawingRequest); end
   endtask

   initial begin
      clear_inputs();
      test_reset();
      test_fire_move();
      test_full();
      test_edge_exit();
      test_hit();
      test_overlap();
      test_fire_sof();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
